seq_step_counter: RTL and testbench
===================================

Name: seq_step_counter

Overview:
- Parametrised, FSM-controlled step counter that supersedes the single-bit combinational incrementer.
- Generates the section, coefficient and state-memory indices for the SOS IIR datapath.
- Counts up or down by a constant STEP between 0 and a run-time limit.
- Supports one-shot or continuous (wrap) operation, with registered terminal-count and done pulses.

Parameters:
- WIDTH, 8, counter and limit width in bits (2..32).
- STEP, 1, increment/decrement amount per enabled cycle (1 .. 2^WIDTH-1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- stop  input  1  abort a run; sampled only in RUN.
- en  input  1  advance count by STEP this cycle (RUN only).
- dir  input  1  1 = count up, 0 = count down; sampled at start.
- cont  input  1  1 = wrap and keep running at boundary, 0 = finish; sampled at start.
- limit  input  WIDTH  upper bound of count range; sampled at start.
- count  output  WIDTH  current index, registered.
- busy  output  1  high while in RUN.
- tc  output  1  one-cycle pulse, boundary reached.
- done  output  1  one-cycle pulse, one-shot run completed.

Behaviour:
- One clock; reset is asynchronous and active-high. Reset asserted at any time, including mid-run, immediately forces: state=IDLE, count=0, busy=0, tc=0, done=0, limit_q=0, dir_q=1, cont_q=0.
- All outputs are registered; no combinational path from input to output.
- FSM states: IDLE, RUN.
- IDLE:
  - count holds its value; en and stop are ignored.
  - On start=1 at an edge: limit_q<=limit, dir_q<=dir, cont_q<=cont; count<=0 if dir=1, else limit; busy<=1; go to RUN.
- RUN:
  - limit, dir and cont changes are ignored; start is ignored.
  - stop=1 has priority over en. Next edge: go to IDLE, busy<=0, count holds, no tc, no done.
  - en=0: count holds.
  - en=1, up, count+STEP <= limit_q (compare at WIDTH+1 bits, no overflow): count<=count+STEP.
  - en=1, down, count >= STEP: count<=count-STEP.
  - en=1 otherwise: boundary event. tc<=1 for one cycle.
    - If cont_q=1: count<=0 (up) or limit_q (down); stay in RUN.
    - If cont_q=0: done<=1 for one cycle, busy<=0, count holds the last value, go to IDLE.
- tc and done are high for exactly one cycle after the boundary edge and are 0 otherwise. done never asserts when cont_q=1.
- Boundary cases:
  - If limit_q < STEP, the first enabled cycle is a boundary event.
  - limit_q=0 with up or down gives count=0 and a boundary on the first en.
  - Up count stops at the largest k*STEP <= limit_q and never exceeds limit_q.
  - Down count reaches the smallest value >= 0 reachable from limit_q and never underflows.
  - start and stop high together in IDLE: start wins.
  - A start in the same cycle as done (first IDLE cycle after RUN) is accepted.
- Latency:
  - start -> busy=1 and initial count: 1 cycle.
  - One-shot up with STEP=1: done at the edge following the (limit_q+1)th enabled cycle.

Test Plan:
- Reset mid-run: WIDTH=8, STEP=1, start up with limit=10, en=1 for 4 cycles (count=3), assert reset asynchronously between edges -> count=0, busy=0, tc=0, done=0 immediately, before the next edge.
- One-shot up: limit=3, dir=1, cont=0, en=1 continuous -> count 0,1,2,3 on successive cycles. Next edge gives tc=1, done=1 for 1 cycle, busy=0, count stays 3.
- Continuous down with STEP=2: limit=7, dir=0, cont=1 -> count 7,5,3,1, then tc pulse with count=7, repeated for 3 wraps. done stays 0 and busy stays 1.
- en gaps and stop: limit=20, en toggled 1,0,1,0 -> count advances only on en=1 cycles. stop=1 together with en=1 at count=2 -> IDLE, count=2, no tc, no done.
- Boundary widths: WIDTH=4, STEP=1, limit=15 up one-shot -> reaches 15, no wrap to 0, done after 16 enabled cycles. STEP=5, limit=3 -> tc and done on the first en, count=0.
- Parameter changes in RUN: limit changed 10->2 and dir toggled mid-run -> ignored, run completes at count=10. start in the done cycle -> new run accepted with the new limit.

Source files
------------

// File: rtl/seq_step_counter.sv
// Step counter for the SOS IIR datapath: walks section/coefficient/state indices
// between 0 and a run-time limit, up or down by STEP, one-shot or wrapping.
module seq_step_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic             cont,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam int unsigned    XW     = WIDTH + 1;
    localparam logic [WIDTH:0] STEP_X = XW'(STEP);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             cont_q, cont_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   upSum;
    logic             canStepUp;
    logic             canStepDown;
    logic             canStep;
    logic [WIDTH-1:0] steppedCount;

    // Comparisons are one bit wider than the counter so count+STEP can never wrap.
    assign upSum        = {1'b0, count_q} + STEP_X;
    assign canStepUp    = (upSum <= {1'b0, limit_q});
    assign canStepDown  = ({1'b0, count_q} >= STEP_X);
    assign canStep      = dir_q ? canStepUp : canStepDown;
    assign steppedCount = dir_q ? upSum[WIDTH-1:0] : (count_q - STEP_X[WIDTH-1:0]);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        cont_d  = cont_q;
        tc_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    limit_d = limit;
                    dir_d   = dir;
                    cont_d  = cont;
                    count_d = dir ? '0 : limit;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (en) begin
                    if (canStep) begin
                        count_d = steppedCount;
                    end else begin
                        tc_d = 1'b1;
                        if (cont_q) begin
                            count_d = dir_q ? '0 : limit_q;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            dir_q   <= 1'b1;
            cont_q  <= 1'b0;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_step_counter.sv
// Directed bench for seq_step_counter: four parameterisations share one stimulus
// bus; each scenario resets first and checks only the instance it targets.
module tb_seq_step_counter;

    logic       clk = 1'b0;
    logic       reset, start, stop, en, dir, cont;
    logic [7:0] limit8;
    logic [3:0] limit4;

    logic [7:0] countA, countB;
    logic [3:0] countC, countD;
    logic       busyA, tcA, doneA;
    logic       busyB, tcB, doneB;
    logic       busyC, tcC, doneC;
    logic       busyD, tcD, doneD;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    seq_step_counter #(.WIDTH(8), .STEP(1)) dutA (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .dir(dir),
        .cont(cont), .limit(limit8), .count(countA), .busy(busyA), .tc(tcA), .done(doneA)
    );
    seq_step_counter #(.WIDTH(8), .STEP(2)) dutB (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .dir(dir),
        .cont(cont), .limit(limit8), .count(countB), .busy(busyB), .tc(tcB), .done(doneB)
    );
    seq_step_counter #(.WIDTH(4), .STEP(1)) dutC (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .dir(dir),
        .cont(cont), .limit(limit4), .count(countC), .busy(busyC), .tc(tcC), .done(doneC)
    );
    seq_step_counter #(.WIDTH(4), .STEP(5)) dutD (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .dir(dir),
        .cont(cont), .limit(limit4), .count(countD), .busy(busyD), .tc(tcD), .done(doneD)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic e, input logic d,
                                 input logic c, input logic [7:0] l8, input logic [3:0] l4);
        start  = s;
        stop   = sp;
        en     = e;
        dir    = d;
        cont   = c;
        limit8 = l8;
        limit4 = l4;
    endtask

    task automatic doReset;
        applyStimulus(0, 0, 0, 0, 0, 8'd0, 4'd0);
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 8'd0, 4'd0);
        doReset;
        checkOutput("reset count", countA, 0);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset tc", tcA, 0);
        checkOutput("reset done", doneA, 0);

        // Asynchronous reset in the middle of a run.
        applyStimulus(1, 0, 0, 1, 0, 8'd10, 4'd0);
        tick;
        applyStimulus(0, 0, 1, 1, 0, 8'd10, 4'd0);
        repeat (3) tick;
        checkOutput("midrun count", countA, 3);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async rst count", countA, 0);
        checkOutput("async rst busy", busyA, 0);
        checkOutput("async rst tc", tcA, 0);
        checkOutput("async rst done", doneA, 0);
        #1;
        reset = 1'b0;

        // One-shot up, limit 3.
        doReset;
        applyStimulus(1, 0, 1, 1, 0, 8'd3, 4'd0);
        tick;
        checkOutput("up1 start count", countA, 0);
        checkOutput("up1 start busy", busyA, 1);
        applyStimulus(0, 0, 1, 1, 0, 8'd3, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            tick;
            checkOutput("up1 count", countA, i);
            checkOutput("up1 tc low", tcA, 0);
        end
        tick;
        checkOutput("up1 tc", tcA, 1);
        checkOutput("up1 done", doneA, 1);
        checkOutput("up1 busy", busyA, 0);
        checkOutput("up1 hold", countA, 3);
        tick;
        checkOutput("up1 tc pulse", tcA, 0);
        checkOutput("up1 done pulse", doneA, 0);
        checkOutput("up1 hold2", countA, 3);

        // Continuous down by 2 from 7, three wraps.
        doReset;
        applyStimulus(1, 0, 0, 0, 1, 8'd7, 4'd0);
        tick;
        checkOutput("dn2 start count", countB, 7);
        checkOutput("dn2 start busy", busyB, 1);
        applyStimulus(0, 0, 1, 0, 1, 8'd7, 4'd0);
        for (int w = 0; w < 3; w++) begin
            for (int k = 1; k <= 3; k++) begin
                tick;
                checkOutput("dn2 count", countB, 7 - 2 * k);
                checkOutput("dn2 tc low", tcB, 0);
            end
            tick;
            checkOutput("dn2 wrap tc", tcB, 1);
            checkOutput("dn2 wrap count", countB, 7);
            checkOutput("dn2 wrap busy", busyB, 1);
            checkOutput("dn2 wrap done", doneB, 0);
        end

        // One-shot down by 2 from 7 stops at 1.
        doReset;
        applyStimulus(1, 0, 0, 0, 0, 8'd7, 4'd0);
        tick;
        applyStimulus(0, 0, 1, 0, 0, 8'd7, 4'd0);
        repeat (3) tick;
        checkOutput("dn2os count", countB, 1);
        tick;
        checkOutput("dn2os done", doneB, 1);
        checkOutput("dn2os hold", countB, 1);
        checkOutput("dn2os busy", busyB, 0);

        // Enable gaps, then stop with en high.
        doReset;
        applyStimulus(1, 0, 0, 1, 0, 8'd20, 4'd0);
        tick;
        checkOutput("gap start", countA, 0);
        applyStimulus(0, 0, 1, 1, 0, 8'd20, 4'd0);
        tick;
        checkOutput("gap en1", countA, 1);
        en = 1'b0;
        tick;
        checkOutput("gap en0", countA, 1);
        en = 1'b1;
        tick;
        checkOutput("gap en1b", countA, 2);
        en = 1'b0;
        tick;
        checkOutput("gap en0b", countA, 2);
        applyStimulus(0, 1, 1, 1, 0, 8'd20, 4'd0);
        tick;
        checkOutput("stop busy", busyA, 0);
        checkOutput("stop count", countA, 2);
        checkOutput("stop tc", tcA, 0);
        checkOutput("stop done", doneA, 0);
        applyStimulus(0, 0, 1, 1, 0, 8'd20, 4'd0);
        tick;
        checkOutput("idle ignores en", countA, 2);
        checkOutput("idle busy", busyA, 0);

        // WIDTH=4 full-range up, no wrap past 15.
        doReset;
        applyStimulus(1, 0, 1, 1, 0, 8'd0, 4'd15);
        tick;
        checkOutput("w4 start count", countC, 0);
        checkOutput("w4 start busy", busyC, 1);
        applyStimulus(0, 0, 1, 1, 0, 8'd0, 4'd15);
        for (int i = 1; i <= 15; i++) begin
            tick;
            checkOutput("w4 count", countC, i);
            checkOutput("w4 done low", doneC, 0);
        end
        tick;
        checkOutput("w4 done", doneC, 1);
        checkOutput("w4 tc", tcC, 1);
        checkOutput("w4 hold", countC, 15);
        checkOutput("w4 busy", busyC, 0);

        // STEP larger than limit: boundary on first enable.
        doReset;
        applyStimulus(1, 0, 0, 1, 0, 8'd0, 4'd3);
        tick;
        checkOutput("s5 start count", countD, 0);
        checkOutput("s5 start busy", busyD, 1);
        applyStimulus(0, 0, 1, 1, 0, 8'd0, 4'd3);
        tick;
        checkOutput("s5 tc", tcD, 1);
        checkOutput("s5 done", doneD, 1);
        checkOutput("s5 count", countD, 0);
        checkOutput("s5 busy", busyD, 0);

        // limit 0 counting down: boundary on first enable.
        doReset;
        applyStimulus(1, 0, 0, 0, 0, 8'd0, 4'd0);
        tick;
        checkOutput("lim0 count", countA, 0);
        applyStimulus(0, 0, 1, 0, 0, 8'd0, 4'd0);
        tick;
        checkOutput("lim0 tc", tcA, 1);
        checkOutput("lim0 done", doneA, 1);
        checkOutput("lim0 hold", countA, 0);

        // Mid-run changes to limit/dir are ignored; restart in the done cycle.
        doReset;
        applyStimulus(1, 0, 1, 1, 0, 8'd10, 4'd0);
        tick;
        repeat (3) tick;
        checkOutput("chg count3", countA, 3);
        applyStimulus(0, 0, 1, 0, 0, 8'd2, 4'd0);
        for (int i = 4; i <= 10; i++) begin
            tick;
            checkOutput("chg count", countA, i);
        end
        tick;
        checkOutput("chg done", doneA, 1);
        checkOutput("chg tc", tcA, 1);
        checkOutput("chg hold", countA, 10);
        applyStimulus(1, 1, 0, 1, 0, 8'd2, 4'd0);
        tick;
        checkOutput("restart busy", busyA, 1);
        checkOutput("restart count", countA, 0);
        checkOutput("restart done", doneA, 0);
        applyStimulus(0, 0, 1, 1, 0, 8'd2, 4'd0);
        tick;
        checkOutput("restart c1", countA, 1);
        tick;
        checkOutput("restart c2", countA, 2);
        tick;
        checkOutput("restart done2", doneA, 1);
        checkOutput("restart hold", countA, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
